// File: rtl/lcd_row_prefetch_if.sv
// Request/stream handshake between the row prefetcher (master) and the pixel source (slave).
interface lcd_row_prefetch_if #(
    parameter int PIX_W = 16
) ();
    logic             req_valid_out;
    logic [7:0]       req_row_out;
    logic             req_ready_in;
    logic             pix_valid_in;
    logic [PIX_W-1:0] pix_data_in;
    logic             pix_ready_out;

    modport master (
        output req_valid_out, req_row_out, pix_ready_out,
        input  req_ready_in, pix_valid_in, pix_data_in
    );

    modport slave (
        input  req_valid_out, req_row_out, pix_ready_out,
        output req_ready_in, pix_valid_in, pix_data_in
    );
endinterface

// File: rtl/lcd_row_prefetch.sv
// Ping-pong line buffer: fetches the row the LCD driver addresses and prefetches its
// successor into the other bank, presenting the displayed bank as a flat pixel vector.
module lcd_row_prefetch #(
    parameter int LCD_W = 132,
    parameter int LCD_H = 162,
    parameter int PIX_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_in,
    input  logic [7:0]             row_addr_in,
    output logic [LCD_W*PIX_W-1:0] row_data_out,
    output logic                   underrun_out,
    output logic                   frame_start_out,
    lcd_row_prefetch_if.master     src
);
    localparam logic [7:0] LAST_ROW = 8'(LCD_H);
    localparam logic [7:0] LAST_X   = 8'(LCD_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL} state_e;

    typedef logic [LCD_W-1:0][PIX_W-1:0] row_t;

    state_e          state_q, state_d;
    row_t [1:0]      bank_q, bank_d;
    logic [1:0][7:0] tag_q, tag_d;
    logic [1:0]      tag_vld_q, tag_vld_d;
    logic [1:0]      cmpl_q, cmpl_d;
    logic [1:0]      filling_q, filling_d;
    logic            disp_q, disp_d;
    logic [7:0]      row_q, row_d;
    logic            tgt_q, tgt_d;
    logic [7:0]      x_q, x_d;
    logic            req_valid_q, req_valid_d;
    logic [7:0]      req_row_q, req_row_d;
    logic            pix_ready_q, pix_ready_d;
    logic            underrun_q, underrun_d;
    logic            frame_start_q, frame_start_d;

    logic [7:0] row_c, succ_row;
    logic       chg, beat, last_beat, hit0, hit1;
    logic [1:0] cmpl_now;
    logic       launch, l_bank, hb, cb;
    logic [7:0] l_row;

    // Rows beyond the last scan line alias onto the last line.
    assign row_c     = (row_addr_in > LAST_ROW) ? LAST_ROW : row_addr_in;
    assign chg       = (row_c != row_q);
    assign succ_row  = (row_q >= LAST_ROW) ? 8'd0 : row_q + 8'd1;
    assign beat      = pix_ready_q && src.pix_valid_in;
    assign last_beat = beat && (x_q == LAST_X);
    // A bank taking its final beat this cycle already counts as complete.
    assign cmpl_now  = cmpl_q | (last_beat ? (2'b01 << tgt_q) : 2'b00);
    assign hit0      = tag_vld_q[0] && (tag_q[0] == row_c);
    assign hit1      = tag_vld_q[1] && (tag_q[1] == row_c);

    always_comb begin
        state_d       = state_q;
        bank_d        = bank_q;
        tag_d         = tag_q;
        tag_vld_d     = tag_vld_q;
        cmpl_d        = cmpl_q;
        filling_d     = filling_q;
        disp_d        = disp_q;
        row_d         = row_q;
        tgt_d         = tgt_q;
        x_d           = x_q;
        req_valid_d   = req_valid_q;
        req_row_d     = req_row_q;
        pix_ready_d   = pix_ready_q;
        underrun_d    = 1'b0;
        frame_start_d = 1'b0;
        launch        = 1'b0;
        l_bank        = disp_q;
        l_row         = row_q;
        hb            = 1'b0;
        cb            = disp_q;

        // Launch only on a quiet cycle so a row switch never races a new target.
        if (state_q == S_IDLE && !chg) begin
            if (!(tag_vld_q[disp_q] && tag_q[disp_q] == row_q)) begin
                launch = 1'b1;
            end else if (!(tag_vld_q[!disp_q] && tag_q[!disp_q] == succ_row)) begin
                launch = 1'b1;
                l_bank = !disp_q;
                l_row  = succ_row;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    state_d           = S_REQ;
                    req_valid_d       = 1'b1;
                    req_row_d         = l_row;
                    tgt_d             = l_bank;
                    tag_d[l_bank]     = l_row;
                    tag_vld_d[l_bank] = 1'b1;
                    cmpl_d[l_bank]    = 1'b0;
                    filling_d[l_bank] = 1'b1;
                    bank_d[l_bank]    = '0;
                end
            end
            S_REQ: begin
                if (req_valid_q && src.req_ready_in) begin
                    state_d     = S_FILL;
                    req_valid_d = 1'b0;
                    pix_ready_d = 1'b1;
                    x_d         = 8'd0;
                end
            end
            S_FILL: begin
                if (beat) begin
                    bank_d[tgt_q][x_q] = src.pix_data_in;
                    x_d                = x_q + 8'd1;
                    if (last_beat) begin
                        cmpl_d[tgt_q]    = 1'b1;
                        filling_d[tgt_q] = 1'b0;
                        pix_ready_d      = 1'b0;
                        state_d          = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (chg) begin
            row_d         = row_c;
            frame_start_d = (row_c == 8'd0);
            if (hit0 || hit1) begin
                hb         = (hit0 && (cmpl_now[0] || !hit1)) ? 1'b0 : 1'b1;
                disp_d     = hb;
                underrun_d = !cmpl_now[hb];
            end else begin
                // Miss: take over the idle bank; any in-flight fill finishes untouched.
                cb            = filling_q[0] ? 1'b1 : (filling_q[1] ? 1'b0 : disp_q);
                bank_d[cb]    = '0;
                tag_vld_d[cb] = 1'b0;
                cmpl_d[cb]    = 1'b0;
                disp_d        = cb;
                underrun_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q       <= S_IDLE;
            bank_q        <= '0;
            tag_q         <= '0;
            tag_vld_q     <= '0;
            cmpl_q        <= '0;
            filling_q     <= '0;
            disp_q        <= 1'b0;
            row_q         <= 8'd0;
            tgt_q         <= 1'b0;
            x_q           <= 8'd0;
            req_valid_q   <= 1'b0;
            req_row_q     <= 8'd0;
            pix_ready_q   <= 1'b0;
            underrun_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bank_q        <= bank_d;
            tag_q         <= tag_d;
            tag_vld_q     <= tag_vld_d;
            cmpl_q        <= cmpl_d;
            filling_q     <= filling_d;
            disp_q        <= disp_d;
            row_q         <= row_d;
            tgt_q         <= tgt_d;
            x_q           <= x_d;
            req_valid_q   <= req_valid_d;
            req_row_q     <= req_row_d;
            pix_ready_q   <= pix_ready_d;
            underrun_q    <= underrun_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign row_data_out      = bank_q[disp_q];
    assign underrun_out      = underrun_q;
    assign frame_start_out   = frame_start_q;
    assign src.req_valid_out = req_valid_q;
    assign src.req_row_out   = req_row_q;
    assign src.pix_ready_out = pix_ready_q;
endmodule

// File: tb/tb_lcd_row_prefetch.sv
// Directed bench for lcd_row_prefetch with a behavioural pixel source (pixel = {row, x}).
module tb_lcd_row_prefetch;
    localparam int LCD_W = 132;
    localparam int LCD_H = 162;
    localparam int PIX_W = 16;

    logic                   clk;
    logic                   rst_in;
    logic [7:0]             row_addr_in;
    logic [LCD_W*PIX_W-1:0] row_data_out;
    logic                   underrun_out;
    logic                   frame_start_out;

    lcd_row_prefetch_if #(.PIX_W(PIX_W)) bus ();

    lcd_row_prefetch #(.LCD_W(LCD_W), .LCD_H(LCD_H), .PIX_W(PIX_W)) dut (
        .clk            (clk),
        .rst_in         (rst_in),
        .row_addr_in    (row_addr_in),
        .row_data_out   (row_data_out),
        .underrun_out   (underrun_out),
        .frame_start_out(frame_start_out),
        .src            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Source model state
    logic       src_act = 1'b0;
    logic [7:0] src_row = 8'd0;
    logic [7:0] src_x = 8'd0;
    logic       stall_en = 1'b0;
    logic [7:0] stall_row = 8'd0;
    logic [7:0] stall_x = 8'd0;
    int         done_cnt = 0;
    int         und_cnt = 0;
    int         fs_cnt = 0;
    logic [7:0] req_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] px(input int x);
        return row_data_out[x*PIX_W +: PIX_W];
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input int k, input int budget, input string tag);
        int n = 0;
        while (done_cnt < k && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(done_cnt >= k), 32'd1);
    endtask

    task automatic wait_req(input int k, input int budget, input string tag);
        int n = 0;
        while (req_log.size() < k && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(req_log.size() >= k), 32'd1);
    endtask

    task automatic wait_src(input logic [7:0] row, input logic [7:0] x, input int budget,
                            input string tag);
        int n = 0;
        while (!(src_act && src_row == row && src_x >= x) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(src_act && src_row == row && src_x >= x), 32'd1);
    endtask

    // Pixel source: always ready for requests, streams {row, x}, optional stall window.
    initial begin
        bus.req_ready_in = 1'b1;
        bus.pix_valid_in = 1'b0;
        bus.pix_data_in  = '0;
        forever begin
            @(negedge clk);
            und_cnt += int'(underrun_out);
            fs_cnt  += int'(frame_start_out);
            if (rst_in) begin
                src_act = 1'b0;
                src_x   = 8'd0;
                bus.pix_valid_in = 1'b0;
            end else begin
                bus.pix_valid_in = src_act &&
                    !(stall_en && src_row == stall_row && src_x >= stall_x);
                bus.pix_data_in  = {src_row, src_x};
                if (bus.pix_valid_in && bus.pix_ready_out) begin
                    src_x = src_x + 8'd1;
                    if (src_x == 8'(LCD_W)) begin
                        src_act = 1'b0;
                        done_cnt++;
                    end
                end
                if (bus.req_valid_out && bus.req_ready_in) begin
                    src_act = 1'b1;
                    src_row = bus.req_row_out;
                    src_x   = 8'd0;
                    req_log.push_back(bus.req_row_out);
                end
            end
        end
    end

    initial begin
        int n;
        rst_in      = 1'b1;
        row_addr_in = 8'd0;
        step(3);
        chk("rst_req_valid", 32'(bus.req_valid_out), 32'd0);
        chk("rst_pix_ready", 32'(bus.pix_ready_out), 32'd0);
        chk("rst_req_row", 32'(bus.req_row_out), 32'd0);
        chk("rst_px0", 32'(px(0)), 32'd0);
        chk("rst_px131", 32'(px(131)), 32'd0);
        chk("rst_underrun", 32'(underrun_out), 32'd0);
        chk("rst_frame_start", 32'(frame_start_out), 32'd0);
        rst_in = 1'b0;

        // 1: initial fills of rows 0 and 1
        wait_done(2, 600, "t1_fill_timeout");
        step(2);
        chk("t1_nreq", 32'(req_log.size()), 32'd2);
        chk("t1_req0", 32'(req_log[0]), 32'd0);
        chk("t1_req1", 32'(req_log[1]), 32'd1);
        chk("t1_px5", 32'(px(5)), 32'h0005);
        chk("t1_px131", 32'(px(131)), 32'h0083);
        chk("t1_pix_ready_low", 32'(bus.pix_ready_out), 32'd0);
        chk("t1_no_underrun", 32'(und_cnt), 32'd0);
        chk("t1_no_frame_start", 32'(fs_cnt), 32'd0);

        // 2: step 0 -> 1, stall armed for row 2 at beat 40
        stall_en = 1'b1; stall_row = 8'd2; stall_x = 8'd40;
        row_addr_in = 8'd1;
        n = req_log.size();
        step(1);
        chk("t2_px5_row1", 32'(px(5)), 32'h0105);
        chk("t2_underrun", 32'(underrun_out), 32'd0);
        wait_req(n + 1, 4, "t2_req_timeout");
        chk("t2_req_row2", 32'(req_log[n]), 32'd2);

        // 3: switch to partially filled row 2
        wait_src(8'd2, 8'd40, 400, "t3_stall_timeout");
        step(2);
        row_addr_in = 8'd2;
        step(1);
        chk("t3_underrun_pulse", 32'(underrun_out), 32'd1);
        chk("t3_px39", 32'(px(39)), 32'h0227);
        chk("t3_px40_zero", 32'(px(40)), 32'h0000);
        chk("t3_px131_zero", 32'(px(131)), 32'h0000);
        step(1);
        chk("t3_underrun_1cyc", 32'(underrun_out), 32'd0);
        chk("t3_und_cnt", 32'(und_cnt), 32'd1);
        n = req_log.size();
        stall_en = 1'b0;
        wait_done(3, 400, "t3_fill_timeout");
        step(2);
        chk("t3_px40_live", 32'(px(40)), 32'h0228);
        chk("t3_px131_live", 32'(px(131)), 32'h0283);
        wait_req(n + 1, 6, "t3_req_timeout");
        chk("t3_req_row3", 32'(req_log[n]), 32'd3);
        wait_done(4, 400, "t3_row3_timeout");
        step(2);

        // 4: jump near frame end, then wrap LCD_H -> 0
        row_addr_in = 8'd161;
        step(1);
        chk("t4_miss_underrun", 32'(underrun_out), 32'd1);
        wait_done(6, 700, "t4_fill_timeout");
        step(2);
        chk("t4_px5_row161", 32'(px(5)), 32'hA105);
        row_addr_in = 8'(LCD_H);
        n = req_log.size();
        step(1);
        chk("t4_px131_row162", 32'(px(131)), 32'hA283);
        chk("t4_last_no_underrun", 32'(underrun_out), 32'd0);
        wait_req(n + 1, 6, "t4_req_timeout");
        chk("t4_prefetch_row0", 32'(req_log[n]), 32'd0);
        wait_done(7, 400, "t4_row0_timeout");
        step(2);
        row_addr_in = 8'd200;
        step(4);
        chk("t4_clamp_no_req", 32'(bus.req_valid_out), 32'd0);
        chk("t4_clamp_no_underrun", 32'(und_cnt), 32'd2);
        chk("t4_clamp_no_fs", 32'(fs_cnt), 32'd0);
        row_addr_in = 8'd0;
        step(1);
        chk("t4_frame_start", 32'(frame_start_out), 32'd1);
        chk("t4_wrap_underrun", 32'(underrun_out), 32'd0);
        chk("t4_px5_row0", 32'(px(5)), 32'h0005);
        step(1);
        chk("t4_frame_start_1cyc", 32'(frame_start_out), 32'd0);
        chk("t4_fs_cnt", 32'(fs_cnt), 32'd1);
        wait_done(8, 400, "t4_row1_timeout");
        step(2);

        // 5: non-sequential jump 7 -> 30 while row 8 is filling
        row_addr_in = 8'd7;
        step(1);
        chk("t5_miss7_underrun", 32'(underrun_out), 32'd1);
        wait_src(8'd8, 8'd20, 700, "t5_row8_timeout");
        row_addr_in = 8'd30;
        n = req_log.size();
        step(1);
        chk("t5_miss30_underrun", 32'(underrun_out), 32'd1);
        chk("t5_px0_zero", 32'(px(0)), 32'h0000);
        chk("t5_px131_zero", 32'(px(131)), 32'h0000);
        wait_req(n + 1, 300, "t5_req30_timeout");
        chk("t5_req30", 32'(req_log[n]), 32'd30);
        chk("t5_px5_still_zero", 32'(px(5)), 32'h0000);
        chk("t5_row8_done", 32'(done_cnt), 32'd10);
        wait_req(n + 2, 400, "t5_req31_timeout");
        chk("t5_req31", 32'(req_log[n+1]), 32'd31);
        chk("t5_px5_row30", 32'(px(5)), 32'h1E05);
        chk("t5_und_cnt", 32'(und_cnt), 32'd4);

        // 6: reset mid-fill of row 31
        wait_src(8'd31, 8'd60, 300, "t6_row31_timeout");
        rst_in = 1'b1;
        step(1);
        chk("t6_req_valid", 32'(bus.req_valid_out), 32'd0);
        chk("t6_pix_ready", 32'(bus.pix_ready_out), 32'd0);
        chk("t6_px5", 32'(px(5)), 32'h0000);
        chk("t6_underrun", 32'(underrun_out), 32'd0);
        chk("t6_frame_start", 32'(frame_start_out), 32'd0);
        row_addr_in = 8'd0;
        step(1);
        rst_in = 1'b0;
        n = req_log.size();
        wait_req(n + 1, 6, "t6_req_timeout");
        chk("t6_restart_row0", 32'(req_log[n]), 32'd0);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lcd_row_prefetch.md
Name: lcd_row_prefetch

Overview:
- Line-buffer controller between a pixel source (renderer or frame store) and the SPI LCD scan driver.
- Watches the row address the driver presents and owns two ping-pong row banks.
- Fetches each row from the source through a request/stream handshake and prefetches the successor row while the current one is shifted out.
- Presents the completed row as a flat pixel vector to the driver.

Parameters:
- LCD_W, 132, pixels per row.
- LCD_H, 162, last row index. A frame is rows 0..LCD_H inclusive, i.e. LCD_H+1 rows, matching the driver scan.
- PIX_W, 16, bits per pixel (RGB565).

Ports:
- clk  in  1  system clock (100 MHz).
- rst_in  in  1  reset, synchronous, active-high.
- row_addr_in  in  8  row index currently addressed by the LCD driver.
- row_data_out  out  LCD_W*PIX_W  displayed row; pixel x at [x*PIX_W +: PIX_W].
- req_valid_out  out  1  row request valid.
- req_row_out  out  8  requested row index.
- req_ready_in  in  1  source accepts request.
- pix_valid_in  in  1  source pixel valid.
- pix_data_in  in  PIX_W  pixel; sent in order x=0..LCD_W-1.
- pix_ready_out  out  1  block accepts pixel.
- underrun_out  out  1  one-cycle pulse: displayed row was incomplete at switch.
- frame_start_out  out  1  one-cycle pulse when row_addr_in changes to 0.

Behaviour:
- Reset (synchronous, rst_in high at clk edge):
  - Both banks cleared to 0; row_data_out = 0.
  - req_valid_out=0, req_row_out=0, pix_ready_out=0, underrun_out=0, frame_start_out=0.
  - Tags invalid; disp_bank=0; row_q=0; fill FSM in IDLE.
  - Reset mid-fill abandons the fill. The source shares rst_in.
- Per-bank state: tag[7:0], complete flag, filling flag.
- Successor: succ(r) = (r >= LCD_H) ? 0 : r+1.
- Fill FSM states: IDLE, REQ, FILL.
  - IDLE -> REQ when a target row is pending. On entry, target bank cleared to 0, tag set, complete=0, filling=1.
  - REQ: req_valid_out=1, req_row_out=target, held stable until req_valid_out && req_ready_in. Then -> FILL with x=0.
  - FILL: pix_ready_out=1. Each pix_valid_in && pix_ready_out writes bank[x] and increments x.
  - After the LCD_W-th beat: complete=1, filling=0, pix_ready_out=0 on the next cycle, -> IDLE.
  - Count x is 8 bits; it never exceeds LCD_W.
- Targets after reset: row 0 into bank 0, then row 1 into bank 1. Both are issued without waiting for a row_addr_in change.
- Row change detection:
  - row_q registers row_addr_in. Change when row_addr_in != row_q; a new value r is evaluated in the cycle it appears.
  - If a bank has tag==r, disp_bank switches to it on the next edge; row_data_out reflects it one cycle after the change.
    - If that bank is not complete: underrun_out pulses with the switch; partial content shows, unwritten pixels 0.
    - The other bank is retargeted to succ(r) once the fill FSM is IDLE. It is never retargeted while filling, and is never the display bank.
  - If no bank has tag==r:
    - underrun_out pulses; the non-filling bank is chosen, cleared, shown, and becomes the next target for r.
    - Any in-flight fill of another row runs to completion (the source is never aborted), then is discarded. r is fetched next, then succ(r).
  - Unchanged row_addr_in: no action; the display bank is never written except by its own pending fill.
- Simultaneous events:
  - A row change in the same cycle as the final pixel beat sees that bank as complete (no underrun).
  - frame_start_out and underrun_out may pulse together.
- row_addr_in > LCD_H is treated as row LCD_H.

Test Plan:
1. Release reset; source ready always, pixels = {row,x}. Required: requests for row 0 then row 1, each 1 req + 132 beats; row_data_out pixel 5 = 16'h0005 after fill; underrun_out never high.
2. Step row_addr_in 0->1 after both fills complete. Required: row_data_out = row 1 data one cycle later; request for row 2 within 2 cycles; no underrun.
3. Source stalls (pix_valid_in low) during row-2 fill; change row to 2 at beat 40. Required: underrun_out 1-cycle pulse; pixels 0..39 valid, 40..131 = 0; remaining beats appear live; succ request row 3 after completion.
4. Row LCD_H -> 0 wrap. Required: prefetch of row 0 issued while on row LCD_H; frame_start_out pulses once; no underrun.
5. Jump row 7 -> 30 (non-sequential) mid-fill of row 8. Required: underrun pulse; row-8 fill completes and is discarded; request 30 then 31; shown bank all zero until row-30 data arrives.
6. Assert rst_in during FILL at beat 60. Required: next cycle all outputs 0, pix_ready_out=0; after release, request row 0 restarts.
